// File: rtl/alu_shift_issue_pipe.sv
// Two-stage issue/retire wrapper around an external combinational shift unit; 2-cycle latency, 1 op/cycle.
// Backpressure: out_ready stalls S2, a stalled S2 stalls S1, and in_ready falls only when both stages hold ops.
module alu_shift_issue_pipe #(
  parameter int TAG_W      = 4,
  parameter int MASK_SHAMT = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [3:0]       in_opcode,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      sh_a,
  output logic [31:0]      sh_b,
  output logic [3:0]       sh_opcode,
  output logic             sh_en,
  input  logic [31:0]      sh_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [CNT_W-1:0] retired_cnt
);

  logic             s1_v, s2_v;
  logic [31:0]      s1_a, s1_b;
  logic [3:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic             opcode_legal, s2_adv, in_fire, out_fire;

  assign opcode_legal = (s1_op == 4'b0101) || (s1_op == 4'b0110) ||
                        (s1_op == 4'b0111) || (s1_op == 4'b1000);

  // S1 may refill in the same cycle it hands its op to S2.
  assign s2_adv   = s1_v && (!s2_v || out_ready);
  assign in_ready = !s1_v || s2_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_v && out_ready;

  assign sh_a      = s1_a;
  assign sh_b      = (MASK_SHAMT != 0) ? {27'b0, s1_b[4:0]} : s1_b;
  assign sh_opcode = s1_op;
  assign sh_en     = s1_v && opcode_legal;
  assign out_valid = s2_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_op  <= '0;
      s1_tag <= '0;
    end else if (in_fire) begin
      s1_v   <= 1'b1;
      s1_a   <= in_a;
      s1_b   <= in_b;
      s1_op  <= in_opcode;
      s1_tag <= in_tag;
    end else if (s2_adv) begin
      s1_v <= 1'b0;
    end
  end

  // Illegal ops still retire, carrying a zero result and the error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v       <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
    end else if (s2_adv) begin
      s2_v       <= 1'b1;
      out_result <= opcode_legal ? sh_result : 32'd0;
      out_tag    <= s1_tag;
      out_err    <= !opcode_legal;
    end else if (out_ready) begin
      s2_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= '0;
    end else if (out_fire) begin
      retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

endmodule
